// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory march self-test controller: FSM state
// codes and the data pattern generator.
package mem_bist_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR0  = 3'd1;
  localparam state_t ST_RD0  = 3'd2;
  localparam state_t ST_WR1  = 3'd3;
  localparam state_t ST_RD1  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  // Wide so any WIDTH/ADDR_WIDTH fits; the caller keeps the low WIDTH bits,
  // which zero-extends or truncates the address as needed.
  function automatic logic [63:0] pattern(input logic [63:0] seed,
                                          input logic [63:0] addr,
                                          input logic        inv);
    logic [63:0] p;
    p = seed ^ addr;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_addr_cnt.sv
// Address counter for one march phase: walks 0..DEPTH-1 and wraps to 0,
// flagging the last address so the FSM can advance.
module mem_bist_addr_cnt #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  assign last = (addr == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (en) begin
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-test driver for a single-port memory with combinational read:
// write P, check P, write ~P, check ~P over every address, then report.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(2 * DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [2:0]            dbg_state
);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      seed_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last;
  logic                  accept;
  logic                  wr_phase, rd_phase, inv;
  logic [63:0]           pat_full;
  logic [WIDTH-1:0]      exp_data;
  logic                  mismatch;

  assign accept   = (state == ST_IDLE) && start;
  assign wr_phase = (state == ST_WR0) || (state == ST_WR1);
  assign rd_phase = (state == ST_RD0) || (state == ST_RD1);
  assign inv      = (state == ST_WR1) || (state == ST_RD1);
  assign busy     = wr_phase || rd_phase;

  mem_bist_addr_cnt #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!busy),
    .en    (busy),
    .addr  (addr),
    .last  (last)
  );

  assign pat_full = pattern(64'(seed_q), 64'(addr), inv);
  assign exp_data = pat_full[WIDTH-1:0];
  assign mismatch = rd_phase && (mem_rdata != exp_data);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WR0;
      ST_WR0:  if (last)  state_nxt = ST_RD0;
      ST_RD0:  if (last)  state_nxt = ST_WR1;
      ST_WR1:  if (last)  state_nxt = ST_RD1;
      ST_RD1:  if (last)  state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seed_q    <= '0;
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        seed_q    <= seed;
        err_count <= '0;
        fail_addr <= '0;
        pass      <= 1'b0;
      end else begin
        if (mismatch) begin
          err_count <= err_count + CNT_WIDTH'(1);
          if (err_count == '0) fail_addr <= addr;
        end
        // The final compare lands on the same edge as the verdict.
        if ((state == ST_RD1) && last) pass <= (err_count == '0) && !mismatch;
      end
    end
  end

  // Memory-side outputs come from registered state and counter only.
  assign mem_wr    = wr_phase;
  assign mem_addr  = busy ? addr : '0;
  assign mem_wdata = wr_phase ? exp_data : '0;
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (DEPTH 16 and 12), each beside a
// behavioural memory with optional read-path fault injection.
module tb_mem_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel;
  logic [7:0] seed;
  logic [1:0] fault_mode;
  logic [3:0] fault_a;

  logic       wr16, busy16, done16, pass16;
  logic [3:0] addr16, fail16;
  logic [7:0] wdata16, rdata16;
  logic [5:0] err16;
  logic [2:0] st16;

  logic       wr12, busy12, done12, pass12;
  logic [3:0] addr12, fail12;
  logic [7:0] wdata12, rdata12;
  logic [4:0] err12;
  logic [2:0] st12;

  logic [7:0] mem16 [16];
  logic [7:0] mem12 [16];

  function automatic logic [7:0] flt(input logic [7:0] d, input logic [3:0] a,
                                     input logic [1:0] m, input logic [3:0] fa);
    if (m == 2'd1 && a == fa) return d & 8'hFE;
    if (m == 2'd2) return 8'h00;
    return d;
  endfunction

  always @(posedge clk) if (wr16) mem16[addr16] <= wdata16;
  always @(posedge clk) if (wr12) mem12[addr12] <= wdata12;
  assign rdata16 = flt(mem16[addr16], addr16, fault_mode, fault_a);
  assign rdata12 = flt(mem12[addr12], addr12, fault_mode, fault_a);

  mem_bist_ctrl #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .seed(seed),
    .mem_wr(wr16), .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16),
    .busy(busy16), .done(done16), .pass(pass16), .fail_addr(fail16),
    .err_count(err16), .dbg_state(st16)
  );

  mem_bist_ctrl #(.WIDTH(8), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .seed(seed),
    .mem_wr(wr12), .mem_addr(addr12), .mem_wdata(wdata12), .mem_rdata(rdata12),
    .busy(busy12), .done(done12), .pass(pass12), .fail_addr(fail12),
    .err_count(err12), .dbg_state(st12)
  );

  logic       o_wr, o_busy, o_done, o_pass;
  logic [3:0] o_addr, o_fail;
  logic [7:0] o_wdata;
  logic [5:0] o_err;
  assign o_wr    = sel ? wr12    : wr16;
  assign o_busy  = sel ? busy12  : busy16;
  assign o_done  = sel ? done12  : done16;
  assign o_pass  = sel ? pass12  : pass16;
  assign o_addr  = sel ? addr12  : addr16;
  assign o_fail  = sel ? fail12  : fail16;
  assign o_wdata = sel ? wdata12 : wdata16;
  assign o_err   = sel ? {1'b0, err12} : err16;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the four march phases over an array standing in for the
  // memory, applying the same read fault the bench memory applies.
  task automatic model(input int depth, input logic [7:0] sd, input logic [1:0] m,
                       input logic [3:0] fa, output int err, output int fail);
    logic [7:0] mem [16];
    logic [7:0] p, rd;
    err  = 0;
    fail = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < depth; a++) begin
        p = sd ^ 8'(a);
        if (ph >= 2) p = ~p;
        if (ph == 0 || ph == 2) begin
          mem[a] = p;
        end else begin
          rd = flt(mem[a], 4'(a), m, fa);
          if (rd != p) begin
            if (err == 0) fail = a;
            err++;
          end
        end
      end
    end
  endtask

  task automatic run(input logic s, input logic [7:0] sd, input int depth,
                     input int exp_err, input int exp_fail, input bit busy_start,
                     input bit done_start);
    int n, busy_n, wr_n, wd_bad, maxa, done_n;
    logic exp_pass;
    exp_pass = (exp_err == 0);
    sel = s;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = ~sd;
    n = 1; busy_n = 0; wr_n = 0; wd_bad = 0; maxa = 0; done_n = -1;
    while (n <= 200) begin
      if (o_busy) busy_n++;
      if (o_wr) wr_n++;
      if (!o_wr && o_wdata != 8'h00) wd_bad++;
      if (int'(o_addr) > maxa) maxa = int'(o_addr);
      start = busy_start && (n == 10);
      if (o_done) begin
        done_n = n;
        chk("pass_at_done", int'(o_pass), int'(exp_pass));
        if (done_start) begin
          start = 1'b1;
          seed  = 8'h3C;
        end
        break;
      end
      @(negedge clk);
      n++;
    end
    if (done_n < 0) chk("done_timeout", 0, 1);
    chk("done_cycle", done_n, 4 * depth + 1);
    chk("busy_cycles", busy_n, 4 * depth);
    chk("wr_cycles", wr_n, 2 * depth);
    chk("wdata_idle_zero", wd_bad, 0);
    chk("max_addr", maxa, depth - 1);
    chk("err_count", int'(o_err), exp_err);
    chk("fail_addr", int'(o_fail), exp_fail);
    @(negedge clk);
    start = 1'b0;
    chk("no_restart_busy", int'(o_busy), 0);
    chk("done_one_cycle", int'(o_done), 0);
    chk("pass_hold", int'(o_pass), int'(exp_pass));
    chk("err_hold", int'(o_err), exp_err);
  endtask

  typedef struct {
    logic       s;
    logic [7:0] sd;
    logic [1:0] m;
    logic [3:0] fa;
    int         err;
    int         fail;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int depth, e_err, e_fail;
    logic [1:0] m;
    logic [7:0] sd;
    logic s;

    vecs[0] = '{1'b0, 8'hA5, 2'd0, 4'd0,  0,  0};
    vecs[1] = '{1'b0, 8'hA5, 2'd1, 4'd5,  1,  5};
    vecs[2] = '{1'b0, 8'hA5, 2'd2, 4'd0, 32,  0};
    vecs[3] = '{1'b0, 8'h03, 2'd2, 4'd0, 31,  0};
    vecs[4] = '{1'b0, 8'h00, 2'd2, 4'd0, 31,  1};
    vecs[5] = '{1'b1, 8'hA5, 2'd0, 4'd0,  0,  0};
    vecs[6] = '{1'b1, 8'h0B, 2'd1, 4'd11, 1, 11};
    vecs[7] = '{1'b1, 8'hFF, 2'd2, 4'd0, 23,  0};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; seed = 8'h00;
    fault_mode = 2'd0; fault_a = 4'd0;
    #1;
    chk("rst_wr16", int'(wr16), 0);
    chk("rst_busy16", int'(busy16), 0);
    chk("rst_done16", int'(done16), 0);
    chk("rst_pass16", int'(pass16), 0);
    chk("rst_err16", int'(err16), 0);
    chk("rst_addr12", int'(addr12), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden run plus the resulting memory image.
    run(1'b0, 8'hA5, 16, 0, 0, 1'b0, 1'b0);
    chk("mem_word3", int'(mem16[3]), 8'h59);

    // Starts while busy and in the DONE cycle are ignored.
    run(1'b0, 8'h5A, 16, 0, 0, 1'b1, 1'b1);
    run(1'b0, 8'h77, 16, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      fault_mode = vecs[i].m;
      fault_a    = vecs[i].fa;
      run(vecs[i].s, vecs[i].sd, vecs[i].s ? 12 : 16, vecs[i].err, vecs[i].fail,
          1'b0, 1'b0);
    end
    fault_mode = 2'd0;

    // Asynchronous reset in the middle of WR0.
    sel = 1'b0;
    @(negedge clk);
    seed = 8'h42; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_wr", int'(wr16), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", int'(wr16), 0);
    chk("async_rst_busy", int'(busy16), 0);
    chk("async_rst_addr", int'(addr16), 0);
    chk("async_rst_wdata", int'(wdata16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy16), 0);
    chk("post_rst_err", int'(err16), 0);
    chk("post_rst_pass", int'(pass16), 0);
    run(1'b0, 8'h42, 16, 0, 0, 1'b0, 1'b0);

    // Randomized runs against the reference model.
    for (int i = 0; i < 16; i++) begin
      s     = 1'($urandom_range(0, 1));
      depth = s ? 12 : 16;
      sd    = 8'($urandom_range(0, 255));
      m     = 2'($urandom_range(0, 2));
      fault_mode = m;
      fault_a    = 4'($urandom_range(0, depth - 1));
      model(depth, sd, m, fault_a, e_err, e_fail);
      run(s, sd, depth, e_err, e_fail, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
